veerwolf_swled: RTL

VEERWOLF_SWLED -- requirements
Module: veerwolf_swled

---
 rtl/veerwolf_swled_pkg.sv | 18 +
 rtl/veerwolf_swled_if.sv | 12 +
 rtl/veerwolf_swled_deb.sv | 56 +++++
 rtl/veerwolf_swled.sv | 104 ++++++++++
 4 files changed

// File: rtl/veerwolf_swled_pkg.sv
// Shared definitions for the switch/LED block: write-target selects and
// counter-width helpers used by the debouncer and the blink prescaler.
package veerwolf_swled_pkg;

  localparam logic SEL_LED   = 1'b0;
  localparam logic SEL_BLINK = 1'b1;

  // Width of a counter that must hold 0..deb_cycles.
  function automatic int unsigned deb_cnt_w(input int unsigned deb_cycles);
    return (deb_cycles < 1) ? 1 : $clog2(deb_cycles + 1);
  endfunction

  // Width of a prescaler that counts 0..div-1.
  function automatic int unsigned pre_cnt_w(input int unsigned div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/veerwolf_swled_if.sv
// Register write bus for the switch/LED block. The master drives the
// strobe, target select and data. The slave (the block) samples them.
interface veerwolf_swled_if #(
  parameter int NUM_CH = 16
);
  logic              i_wr_en;
  logic              i_wr_sel;
  logic [NUM_CH-1:0] i_wr_data;

  modport master (output i_wr_en, output i_wr_sel, output i_wr_data);
  modport slave  (input  i_wr_en, input  i_wr_sel, input  i_wr_data);
endinterface

// File: rtl/veerwolf_swled_deb.sv
// One switch debounce channel: 2-flop synchroniser, stability counter,
// debounced level and a one-cycle change pulse.
module veerwolf_swled_deb
  import veerwolf_swled_pkg::*;
#(
  parameter int DEB_CYCLES = 50000
) (
  input  logic clk_core,
  input  logic rst_core,
  input  logic sw_raw,
  output logic sw_db,
  output logic sw_chg
);

  localparam int CNT_W = deb_cnt_w(DEB_CYCLES);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt_p2;
  logic             differ;
  logic             accept;

  assign differ = sync_p1 ^ sw_db;
  assign accept = differ && (cnt_p2 == CNT_W'(DEB_CYCLES - 1));

  // Stage p0/p1: bring the asynchronous switch level into the clock domain.
  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= sw_raw;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: count consecutive differing cycles; any bounce restarts the count.
  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      cnt_p2 <= '0;
      sw_db  <= 1'b0;
      sw_chg <= 1'b0;
    end else begin
      sw_chg <= accept;
      if (accept) begin
        sw_db  <= ~sw_db;
        cnt_p2 <= '0;
      end else if (differ) begin
        cnt_p2 <= cnt_p2 + CNT_W'(1);
      end else begin
        cnt_p2 <= '0;
      end
    end
  end

endmodule

// File: rtl/veerwolf_swled.sv
// Switch debouncer bank plus LED output register.
// Optional blink support (per-channel blink mask, free-running prescaler and
// phase bit) is compiled in only when VEERWOLF_SWLED_BLINK_EN is defined.
// Without it, blink-mask writes are ignored and o_led follows the LED value.
module veerwolf_swled
  import veerwolf_swled_pkg::*;
#(
  parameter int NUM_CH     = 16,
  parameter int DEB_CYCLES = 50000,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                 clk_core,
  input  logic                 rst_core,
  input  logic [NUM_CH-1:0]    i_sw,
  output logic [NUM_CH-1:0]    o_sw_db,
  output logic [NUM_CH-1:0]    o_sw_chg,
  veerwolf_swled_if.slave      wr,
  output logic [NUM_CH-1:0]    o_led
);

  if (NUM_CH < 1 || NUM_CH > 64 || DEB_CYCLES < 1 || BLINK_DIV < 2) begin : g_bad_param
    $error("veerwolf_swled: parameter out of range");
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    veerwolf_swled_deb #(
      .DEB_CYCLES (DEB_CYCLES)
    ) u_deb (
      .clk_core (clk_core),
      .rst_core (rst_core),
      .sw_raw   (i_sw[g]),
      .sw_db    (o_sw_db[g]),
      .sw_chg   (o_sw_chg[g])
    );
  end

  logic              wr_led;
  logic [NUM_CH-1:0] led_val;
  logic [NUM_CH-1:0] led_val_nxt;
  logic [NUM_CH-1:0] led_drv_nxt;

  assign wr_led = wr.i_wr_en && (wr.i_wr_sel == SEL_LED);

  // Next LED value: a write replaces it, otherwise it holds.
  always_comb begin
    led_val_nxt = led_val;
    if (wr_led) led_val_nxt = wr.i_wr_data;
  end

`ifdef VEERWOLF_SWLED_BLINK_EN
  localparam int PRE_W = pre_cnt_w(BLINK_DIV);

  logic              wr_blink;
  logic [PRE_W-1:0]  pre;
  logic [PRE_W-1:0]  pre_nxt;
  logic              phase;
  logic              phase_nxt;
  logic              wrap;
  logic [NUM_CH-1:0] blink_mask;
  logic [NUM_CH-1:0] blink_mask_nxt;

  assign wr_blink = wr.i_wr_en && (wr.i_wr_sel == SEL_BLINK);
  assign wrap     = (pre == PRE_W'(BLINK_DIV - 1));

  // Prescaler, phase and mask next-state; mask writes never disturb the prescaler.
  always_comb begin
    pre_nxt        = wrap ? '0 : pre + PRE_W'(1);
    phase_nxt      = phase ^ wrap;
    blink_mask_nxt = blink_mask;
    if (wr_blink) blink_mask_nxt = wr.i_wr_data;
    led_drv_nxt    = led_val_nxt & (~blink_mask_nxt | {NUM_CH{phase_nxt}});
  end

  // Blink state registers.
  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      pre        <= '0;
      phase      <= 1'b0;
      blink_mask <= '0;
    end else begin
      pre        <= pre_nxt;
      phase      <= phase_nxt;
      blink_mask <= blink_mask_nxt;
    end
  end
`else
  // Without blink support the LED drive is simply the next LED value.
  always_comb begin
    led_drv_nxt = led_val_nxt;
  end
`endif

  // LED value and output register, both loaded from next-state values.
  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      led_val <= '0;
      o_led   <= '0;
    end else begin
      led_val <= led_val_nxt;
      o_led   <= led_drv_nxt;
    end
  end

endmodule
